// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types: condition codes, NZCV flag indices, branch-unit states
package cpu_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_HS = 4'h2, COND_LO = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    localparam logic [1:0] FLAG_N = 2'd3;
    localparam logic [1:0] FLAG_Z = 2'd2;
    localparam logic [1:0] FLAG_C = 2'd1;
    localparam logic [1:0] FLAG_V = 2'd0;

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} bcu_state_e;

endpackage

// File: rtl/branch_cond_unit_if.sv
// rtl/branch_cond_unit_if.sv - decode-stage branch resolver signal bundle
interface branch_cond_unit_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       flags_q;
    logic [3:0]       ex_flags;
    logic             ex_setflags;
    logic             id_valid;
    logic             id_flush;
    logic             id_is_b;
    logic             id_is_bcond;
    logic             id_is_cbz;
    logic [3:0]       id_cond;
    logic             id_rt_zero;
    logic             stall_id;
    logic             br_taken;
    logic             br_redirect;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output flags_q, ex_flags, ex_setflags, id_valid, id_flush,
               id_is_b, id_is_bcond, id_is_cbz, id_cond, id_rt_zero,
        input  stall_id, br_taken, br_redirect, branch_cnt, taken_cnt
    );

    modport slave (
        input  flags_q, ex_flags, ex_setflags, id_valid, id_flush,
               id_is_b, id_is_bcond, id_is_cbz, id_cond, id_rt_zero,
        output stall_id, br_taken, br_redirect, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition-code evaluator over {N,Z,C,V}
module cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] nzcv,
    input  logic [3:0] cond,
    output logic       cond_true
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    always_comb begin
        cond_true = 1'b1;
        case (cond_e'(cond))
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_HS: cond_true = c;
            COND_LO: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = c & ~z;
            COND_LS: cond_true = ~c | z;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            default: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - resolves B / B.cond / CBZ in decode, interlocks on EX flag writes
module branch_cond_unit
    import cpu_pkg::*;
#(
    parameter int CNT_W             = 16,
    parameter bit STALL_ON_SETFLAGS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    branch_cond_unit_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bcu_state_e state;
    logic       live, is_b, is_bcond, is_cbz, branch;
    logic       stall_req, resolve, taken, cond_true;
    logic [3:0] nzcv_sel;

    assign live     = bus.id_valid & ~bus.id_flush;
    // One-hot the instruction type so B beats B.cond beats CBZ.
    assign is_b     = bus.id_is_b;
    assign is_bcond = bus.id_is_bcond & ~bus.id_is_b;
    assign is_cbz   = bus.id_is_cbz & ~bus.id_is_bcond & ~bus.id_is_b;
    assign branch   = live & (is_b | is_bcond | is_cbz);

    assign nzcv_sel = (!STALL_ON_SETFLAGS && bus.ex_setflags) ? bus.ex_flags : bus.flags_q;

    cond_check u_cond_check (
        .nzcv      (nzcv_sel),
        .cond      (bus.id_cond),
        .cond_true (cond_true)
    );

    // A flush in WAIT drops live, so the held B.cond is simply never resolved.
    assign stall_req    = STALL_ON_SETFLAGS && (state == RUN) && live && is_bcond && bus.ex_setflags;
    assign resolve      = branch & ~stall_req;
    assign taken        = is_b | (is_bcond & cond_true) | (is_cbz & bus.id_rt_zero);
    assign bus.stall_id = stall_req & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= RUN;
            bus.br_taken    <= 1'b0;
            bus.br_redirect <= 1'b0;
            bus.branch_cnt  <= '0;
            bus.taken_cnt   <= '0;
        end else begin
            state           <= stall_req ? WAIT : RUN;
            bus.br_taken    <= resolve & taken;
            bus.br_redirect <= resolve & taken;
            if (resolve && bus.branch_cnt != CNT_MAX)
                bus.branch_cnt <= bus.branch_cnt + CNT_ONE;
            if (resolve && taken && bus.taken_cnt != CNT_MAX)
                bus.taken_cnt <= bus.taken_cnt + CNT_ONE;
        end
    end

endmodule
